// File: rtl/mips16_ctrl_pkg.sv
// Shared encodings for the MIPS16 PC sequencer: pc_src codes, jr decode constants, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips16_ctrl_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;
  localparam logic [1:0] PCSRC_JR  = 2'b11;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [3:0] FUNCT_JR    = 4'b1000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_ctrl_if.sv
// Bundle between decode/hazard/IMEM side and the PC sequencer.
// Latency: n/a (wires only).
// Backpressure: stall is the only flow control; it freezes the sequencer.
interface pc_redirect_ctrl_if #(
  parameter int PC_W = 16
);
  logic [1:0]      aluop;
  logic [3:0]      funct;
  logic            jump;
  logic            branch;
  logic            zero;
  logic            stall;
  logic [PC_W-1:0] jr_target;
  logic [PC_W-1:0] jump_target;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] pc;
  logic [1:0]      pc_src;
  logic            flush;
  logic            jr_taken;
  logic            align_err;

  // Decode / hazard side: drives requests, observes the PC.
  modport master (
    output aluop, funct, jump, branch, zero, stall,
    output jr_target, jump_target, branch_target,
    input  pc, pc_src, flush, jr_taken, align_err
  );

  // Sequencer side.
  modport slave (
    input  aluop, funct, jump, branch, zero, stall,
    input  jr_target, jump_target, branch_target,
    output pc, pc_src, flush, jr_taken, align_err
  );
endinterface

// File: rtl/pc_redirect_ctrl_decode.sv
// Priority decode of jr > jump > taken branch into valid, pc_src code and target.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the request is consumed.
module redirect_decode
  import mips16_ctrl_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic [1:0]      aluop_i,
  input  logic [3:0]      funct_i,
  input  logic            jump_i,
  input  logic            branch_i,
  input  logic            zero_i,
  input  logic [PC_W-1:0] jr_target_i,
  input  logic [PC_W-1:0] jump_target_i,
  input  logic [PC_W-1:0] branch_target_i,
  output logic            req_vld_o,
  output logic [1:0]      req_src_o,
  output logic [PC_W-1:0] req_tgt_o
);

  logic jr_req;
  assign jr_req = (aluop_i == ALUOP_RTYPE) && (funct_i == FUNCT_JR);

  // Highest-priority request wins; target is the raw (unaligned) address.
  always_comb begin
    req_vld_o = 1'b0;
    req_src_o = PCSRC_SEQ;
    req_tgt_o = '0;
    if (jr_req) begin
      req_vld_o = 1'b1;
      req_src_o = PCSRC_JR;
      req_tgt_o = jr_target_i;
    end else if (jump_i) begin
      req_vld_o = 1'b1;
      req_src_o = PCSRC_J;
      req_tgt_o = jump_target_i;
    end else if (branch_i && zero_i) begin
      req_vld_o = 1'b1;
      req_src_o = PCSRC_BR;
      req_tgt_o = branch_target_i;
    end
  end

endmodule

// File: rtl/pc_redirect_ctrl.sv
// PC register and redirect FSM: advances PC by 2, loads redirect targets and raises flush.
// Latency: request sampled at edge N -> pc=target after N; flush high N+1..N+FLUSH_CYCLES.
// Backpressure: stall freezes PC/FSM/counter/flush; a stalled request must be re-presented.
module pc_redirect_ctrl
  import mips16_ctrl_pkg::*;
#(
  parameter int              PC_W         = 16,
  parameter logic [PC_W-1:0] RESET_PC     = '0,
  parameter int              FLUSH_CYCLES = 1
) (
  input logic                clk,
  input logic                rst_n,
  pc_redirect_ctrl_if.slave  bus
);

  pc_state_e       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [1:0]      pc_src_q, pc_src_d;
  logic            flush_q, flush_d;
  logic            jr_taken_q, jr_taken_d;
  logic            align_err_q, align_err_d;

  logic            req_vld;
  logic [1:0]      req_src;
  logic [PC_W-1:0] req_tgt;

  redirect_decode #(.PC_W(PC_W)) u_decode (
    .aluop_i         (bus.aluop),
    .funct_i         (bus.funct),
    .jump_i          (bus.jump),
    .branch_i        (bus.branch),
    .zero_i          (bus.zero),
    .jr_target_i     (bus.jr_target),
    .jump_target_i   (bus.jump_target),
    .branch_target_i (bus.branch_target),
    .req_vld_o       (req_vld),
    .req_src_o       (req_src),
    .req_tgt_o       (req_tgt)
  );

  // Next-state: sequential advance, redirect in RUN, flush countdown in FLUSH; stall holds all.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    pc_src_d    = pc_src_q;
    flush_d     = flush_q;
    jr_taken_d  = 1'b0;
    align_err_d = align_err_q;
    if (!bus.stall) begin
      unique case (state_q)
        ST_RUN: begin
          if (req_vld) begin
            pc_d        = {req_tgt[PC_W-1:1], 1'b0};
            pc_src_d    = req_src;
            align_err_d = align_err_q | req_tgt[0];
            cnt_d       = 3'(FLUSH_CYCLES);
            flush_d     = 1'b1;
            state_d     = ST_FLUSH;
            jr_taken_d  = (req_src == PCSRC_JR);
          end else begin
            pc_d     = pc_q + PC_W'(2);
            pc_src_d = PCSRC_SEQ;
          end
        end
        ST_FLUSH: begin
          // Requests here belong to squashed wrong-path instructions.
          pc_d     = pc_q + PC_W'(2);
          pc_src_d = PCSRC_SEQ;
          cnt_d    = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            flush_d = 1'b0;
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // State and output registers; reset drops any in-progress flush at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      pc_q        <= RESET_PC;
      pc_src_q    <= PCSRC_SEQ;
      flush_q     <= 1'b0;
      jr_taken_q  <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      pc_src_q    <= pc_src_d;
      flush_q     <= flush_d;
      jr_taken_q  <= jr_taken_d;
      align_err_q <= align_err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.pc_src    = pc_src_q;
  assign bus.flush     = flush_q;
  assign bus.jr_taken  = jr_taken_q;
  assign bus.align_err = align_err_q;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Scoreboard bench for pc_redirect_ctrl: two instances (RESET_PC=0/FLUSH=1 and RESET_PC=FFFC/FLUSH=3).
// Stimulus pushes the expected post-edge outputs; a monitor pops and compares after each edge.
// Asynchronous reset effects are checked directly without a clock edge.
module tb_pc_redirect_ctrl;

  logic clk;
  logic rst_n;

  pc_redirect_ctrl_if #(.PC_W(16)) ia ();
  pc_redirect_ctrl_if #(.PC_W(16)) ib ();

  pc_redirect_ctrl #(.PC_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ia.slave)
  );

  pc_redirect_ctrl #(.PC_W(16), .RESET_PC(16'hFFFC), .FLUSH_CYCLES(3)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ib.slave)
  );

  typedef struct {
    bit          sel;
    logic [15:0] pc;
    logic [1:0]  src;
    logic        fl;
    logic        jr;
    logic        al;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   cur_sel = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input bit sel, input string tag, input logic [15:0] pc,
                         input logic [1:0] src, input logic fl, input logic jr, input logic al);
    if (!sel) begin
      chk({tag, ".a.pc"},        ia.pc,               pc);
      chk({tag, ".a.pc_src"},    {14'd0, ia.pc_src},  {14'd0, src});
      chk({tag, ".a.flush"},     {15'd0, ia.flush},   {15'd0, fl});
      chk({tag, ".a.jr_taken"},  {15'd0, ia.jr_taken},{15'd0, jr});
      chk({tag, ".a.align_err"}, {15'd0, ia.align_err},{15'd0, al});
    end else begin
      chk({tag, ".b.pc"},        ib.pc,               pc);
      chk({tag, ".b.pc_src"},    {14'd0, ib.pc_src},  {14'd0, src});
      chk({tag, ".b.flush"},     {15'd0, ib.flush},   {15'd0, fl});
      chk({tag, ".b.jr_taken"},  {15'd0, ib.jr_taken},{15'd0, jr});
      chk({tag, ".b.align_err"}, {15'd0, ib.align_err},{15'd0, al});
    end
  endtask

  // Monitor: every edge is an output beat; compare against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk_all(e.sel, "step", e.pc, e.src, e.fl, e.jr, e.al);
    end
  end

  task automatic set_idle();
    ia.aluop = 2'b00; ia.funct = 4'h0; ia.jump = 1'b0; ia.branch = 1'b0; ia.zero = 1'b0;
    ia.stall = 1'b0; ia.jr_target = 16'h0; ia.jump_target = 16'h0; ia.branch_target = 16'h0;
    ib.aluop = 2'b00; ib.funct = 4'h0; ib.jump = 1'b0; ib.branch = 1'b0; ib.zero = 1'b0;
    ib.stall = 1'b0; ib.jr_target = 16'h0; ib.jump_target = 16'h0; ib.branch_target = 16'h0;
  endtask

  task automatic drive(input logic [1:0] aluop, input logic [3:0] funct, input logic j,
                       input logic b, input logic z, input logic st, input logic [15:0] jrt,
                       input logic [15:0] jt, input logic [15:0] bt);
    set_idle();
    if (!cur_sel) begin
      ia.aluop = aluop; ia.funct = funct; ia.jump = j; ia.branch = b; ia.zero = z;
      ia.stall = st; ia.jr_target = jrt; ia.jump_target = jt; ia.branch_target = bt;
    end else begin
      ib.aluop = aluop; ib.funct = funct; ib.jump = j; ib.branch = b; ib.zero = z;
      ib.stall = st; ib.jr_target = jrt; ib.jump_target = jt; ib.branch_target = bt;
    end
  endtask

  // Push the expected post-edge outputs, cross the edge, return at the next falling edge.
  task automatic expect_step(input logic [15:0] pc, input logic [1:0] src,
                             input logic fl, input logic jr, input logic al);
    exp_t e;
    e.sel = cur_sel; e.pc = pc; e.src = src; e.fl = fl; e.jr = jr; e.al = al;
    q.push_back(e);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_step(input logic [15:0] pc, input logic [1:0] src,
                           input logic fl, input logic jr, input logic al);
    drive(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    expect_step(pc, src, fl, jr, al);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all(1'b0, "reset", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);

    // Instance A: RESET_PC=0000, FLUSH_CYCLES=1.
    cur_sel = 1'b0;
    idle_step(16'h0002, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_step(16'h0004, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_step(16'h0006, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_step(16'h0008, 2'b00, 1'b0, 1'b0, 1'b0);
    // jr at pc=0008
    drive(2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0040, 16'h0, 16'h0);
    expect_step(16'h0040, 2'b11, 1'b1, 1'b1, 1'b0);
    idle_step(16'h0042, 2'b00, 1'b0, 1'b0, 1'b0);
    // jump beats taken branch
    drive(2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0100, 16'h0200);
    expect_step(16'h0100, 2'b10, 1'b1, 1'b0, 1'b0);
    idle_step(16'h0102, 2'b00, 1'b0, 1'b0, 1'b0);
    // stall with jump held two cycles, then released
    drive(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0300, 16'h0);
    expect_step(16'h0102, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0300, 16'h0);
    expect_step(16'h0102, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0300, 16'h0);
    expect_step(16'h0300, 2'b10, 1'b1, 1'b0, 1'b0);
    idle_step(16'h0302, 2'b00, 1'b0, 1'b0, 1'b0);
    // branch not taken, near-miss jr encodings
    drive(2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0500);
    expect_step(16'h0304, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b10, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0, 16'h0);
    expect_step(16'h0306, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0700, 16'h0, 16'h0);
    expect_step(16'h0308, 2'b00, 1'b0, 1'b0, 1'b0);
    // misaligned jr target, then jr held into the flush cycle (ignored)
    drive(2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0031, 16'h0, 16'h0);
    expect_step(16'h0030, 2'b11, 1'b1, 1'b1, 1'b1);
    drive(2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0060, 16'h0, 16'h0);
    expect_step(16'h0032, 2'b00, 1'b0, 1'b0, 1'b1);
    idle_step(16'h0034, 2'b00, 1'b0, 1'b0, 1'b1);
    // stall right after a jr: jr_taken clears, flush/pc_src hold
    drive(2'b10, 4'b1000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0050, 16'h0, 16'h0);
    expect_step(16'h0050, 2'b11, 1'b1, 1'b1, 1'b1);
    drive(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    expect_step(16'h0050, 2'b11, 1'b1, 1'b0, 1'b1);
    idle_step(16'h0052, 2'b00, 1'b0, 1'b0, 1'b1);
    idle_step(16'h0054, 2'b00, 1'b0, 1'b0, 1'b1);

    // Reset clears the sticky align_err without a clock edge.
    rst_n = 1'b0;
    #1;
    chk_all(1'b0, "arst_a", 16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_all(1'b1, "reset_b", 16'hFFFC, 2'b00, 1'b0, 1'b0, 1'b0);

    // Instance B: RESET_PC=FFFC, FLUSH_CYCLES=3.
    cur_sel = 1'b1;
    idle_step(16'hFFFE, 2'b00, 1'b0, 1'b0, 1'b0);
    idle_step(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
    drive(2'b00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0200);
    expect_step(16'h0200, 2'b01, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0400);
    expect_step(16'h0202, 2'b00, 1'b1, 1'b0, 1'b0);
    idle_step(16'h0204, 2'b00, 1'b1, 1'b0, 1'b0);
    idle_step(16'h0206, 2'b00, 1'b0, 1'b0, 1'b0);
    // stall in the middle of a flush stretches it by one cycle
    drive(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h1000, 16'h0);
    expect_step(16'h1000, 2'b10, 1'b1, 1'b0, 1'b0);
    drive(2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
    expect_step(16'h1000, 2'b10, 1'b1, 1'b0, 1'b0);
    idle_step(16'h1002, 2'b00, 1'b1, 1'b0, 1'b0);
    idle_step(16'h1004, 2'b00, 1'b1, 1'b0, 1'b0);
    idle_step(16'h1006, 2'b00, 1'b0, 1'b0, 1'b0);
    // async reset mid-flush
    drive(2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h2000, 16'h0);
    expect_step(16'h2000, 2'b10, 1'b1, 1'b0, 1'b0);
    idle_step(16'h2002, 2'b00, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all(1'b1, "arst_b", 16'hFFFC, 2'b00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    idle_step(16'hFFFE, 2'b00, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
